cpu7_excp_ctl: RTL and testbench

//  Exception/ERTN sequencer between the _e stage and the CSR file. Takes raw exception and ertn

---
 rtl/cpu7_excp_ctl_pkg.sv | 10 +
 rtl/cpu7_excp_ctl_if.sv | 32 +++
 rtl/cpu7_excp_ctl.sv | 61 ++++++
 tb/tb_cpu7_excp_ctl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu7_excp_ctl_pkg.sv
// cpu7_excp_ctl_pkg: state encodings and ecode constants for the exception sequencer
package cpu7_excp_ctl_pkg;
  typedef enum logic [1:0] {
    EXCP_IDLE     = 2'd0,
    EXCP_DRAIN    = 2'd1,
    EXCP_REDIRECT = 2'd2
  } excp_state_t;
  localparam logic [5:0] LSOC1K_ECODE_ALE = 6'h09;
  localparam logic [5:0] LSOC1K_ECODE_INE = 6'h0D;
endpackage

// File: rtl/cpu7_excp_ctl_if.sv
// cpu7_excp_ctl_if: pipeline/LSU/CSR/fetch signals around the exception sequencer
interface cpu7_excp_ctl_if #(
  parameter int GRLEN = 32
);
  logic             exu_excp_valid_e;
  logic             ecl_excp_ale_e;
  logic             ecl_excp_illinst_e;
  logic             ecl_excp_ertn_e;
  logic             lsu_excp_busy;
  logic [GRLEN-1:0] csr_eentry;
  logic [GRLEN-1:0] csr_era;
  logic             ecl_csr_ale_e;
  logic             ecl_csr_illinst_e;
  logic             ecl_csr_ertn_e;
  logic             excp_pipe_flush;
  logic             excp_ifu_redirect;
  logic [GRLEN-1:0] excp_ifu_redirect_pc;
  logic [5:0]       excp_ecode;
  logic             excp_drain_timeout;
  modport master (
    output exu_excp_valid_e, ecl_excp_ale_e, ecl_excp_illinst_e, ecl_excp_ertn_e,
           lsu_excp_busy, csr_eentry, csr_era,
    input  ecl_csr_ale_e, ecl_csr_illinst_e, ecl_csr_ertn_e, excp_pipe_flush,
           excp_ifu_redirect, excp_ifu_redirect_pc, excp_ecode, excp_drain_timeout
  );
  modport slave (
    input  exu_excp_valid_e, ecl_excp_ale_e, ecl_excp_illinst_e, ecl_excp_ertn_e,
           lsu_excp_busy, csr_eentry, csr_era,
    output ecl_csr_ale_e, ecl_csr_illinst_e, ecl_csr_ertn_e, excp_pipe_flush,
           excp_ifu_redirect, excp_ifu_redirect_pc, excp_ecode, excp_drain_timeout
  );
endinterface

// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl: arbitrates exception/ertn requests, commits to CSR, drains LSU, redirects fetch
module cpu7_excp_ctl
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int DRAIN_CNT_W = 4
) (
  input logic            clk,
  input logic            reset,
  cpu7_excp_ctl_if.slave bus
);
  excp_state_t state, state_nxt;
  logic [DRAIN_CNT_W-1:0] cnt, cnt_inc;
  logic [5:0] ecode;
  logic kind, timeout, accept, expire, redirect;
  assign accept = !reset && state == EXCP_IDLE && bus.exu_excp_valid_e &&
                  (bus.ecl_excp_ale_e || bus.ecl_excp_illinst_e || bus.ecl_excp_ertn_e);
  assign cnt_inc = cnt + 1'b1;
  assign expire = bus.lsu_excp_busy && (&cnt_inc);
  assign redirect = !reset && state == EXCP_REDIRECT;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= EXCP_IDLE;
    else state <= state_nxt;
  end
  // next state: leave DRAIN when LSU is idle or the watchdog is about to saturate
  always_comb begin
    state_nxt = state == EXCP_IDLE  ? (accept ? EXCP_DRAIN : EXCP_IDLE) :
                state == EXCP_DRAIN ? ((!bus.lsu_excp_busy || expire) ? EXCP_REDIRECT : EXCP_DRAIN) :
                EXCP_IDLE;
  end
  // kind/ecode capture at accept, drain counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (reset) begin
      kind    <= 1'b0;
      ecode   <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept) begin
        kind  <= bus.ecl_excp_illinst_e || bus.ecl_excp_ale_e;
        ecode <= bus.ecl_excp_illinst_e ? LSOC1K_ECODE_INE :
                 bus.ecl_excp_ale_e     ? LSOC1K_ECODE_ALE : ecode;
        cnt   <= '0;
      end else if (state == EXCP_DRAIN && bus.lsu_excp_busy) begin
        cnt <= (&cnt) ? cnt : cnt_inc;
      end
      if (state == EXCP_DRAIN && expire) timeout <= 1'b1;
    end
  end
  // outputs: commit pulses in the accept cycle, flush until redirect completes
  always_comb begin
    bus.ecl_csr_illinst_e    = accept && bus.ecl_excp_illinst_e;
    bus.ecl_csr_ale_e        = accept && !bus.ecl_excp_illinst_e && bus.ecl_excp_ale_e;
    bus.ecl_csr_ertn_e       = accept && !bus.ecl_excp_illinst_e && !bus.ecl_excp_ale_e;
    bus.excp_pipe_flush      = accept || (!reset && state != EXCP_IDLE);
    bus.excp_ifu_redirect    = redirect;
    bus.excp_ifu_redirect_pc = redirect ? (kind ? bus.csr_eentry : bus.csr_era) : '0;
    bus.excp_ecode           = ecode;
    bus.excp_drain_timeout   = timeout;
  end
endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// tb_cpu7_excp_ctl: directed checks of the exception/ertn sequencer
module tb_cpu7_excp_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  cpu7_excp_ctl_if #(.GRLEN(32)) bus ();
  cpu7_excp_ctl #(.DRAIN_CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic ale, input logic ill, input logic ertn);
    bus.exu_excp_valid_e   = ale | ill | ertn;
    bus.ecl_excp_ale_e     = ale;
    bus.ecl_excp_illinst_e = ill;
    bus.ecl_excp_ertn_e    = ertn;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.csr_eentry = 32'h1C000100;
    bus.csr_era = 32'h1C000204;
    bus.lsu_excp_busy = 1'b0;
    req(0, 0, 0);
    step();
    step();
    reset = 1'b0;
    chk("rst_flush", bus.excp_pipe_flush, 0);
    chk("rst_redir", bus.excp_ifu_redirect, 0);
    chk("rst_ecode", bus.excp_ecode, 0);
    chk("rst_tmo", bus.excp_drain_timeout, 0);
    chk("rst_pc", bus.excp_ifu_redirect_pc, 0);
    step();
    req(1, 0, 0);
    chk("ale_pulse", bus.ecl_csr_ale_e, 1);
    chk("ale_ine0", bus.ecl_csr_illinst_e, 0);
    chk("ale_ertn0", bus.ecl_csr_ertn_e, 0);
    chk("ale_flushT", bus.excp_pipe_flush, 1);
    step();
    req(0, 0, 0);
    chk("ale_flushT1", bus.excp_pipe_flush, 1);
    chk("ale_redirT1", bus.excp_ifu_redirect, 0);
    chk("ale_ecode", bus.excp_ecode, 6'h09);
    step();
    chk("ale_redirT2", bus.excp_ifu_redirect, 1);
    chk("ale_pc", bus.excp_ifu_redirect_pc, 32'h1C000100);
    chk("ale_flushT2", bus.excp_pipe_flush, 1);
    step();
    chk("ale_redirT3", bus.excp_ifu_redirect, 0);
    chk("ale_flushT3", bus.excp_pipe_flush, 0);
    req(1, 1, 0);
    chk("pri_ine", bus.ecl_csr_illinst_e, 1);
    chk("pri_ale0", bus.ecl_csr_ale_e, 0);
    chk("pri_ertn0", bus.ecl_csr_ertn_e, 0);
    step();
    req(0, 0, 0);
    chk("pri_ecode", bus.excp_ecode, 6'h0D);
    step();
    chk("pri_redir", bus.excp_ifu_redirect, 1);
    chk("pri_pc", bus.excp_ifu_redirect_pc, 32'h1C000100);
    step();
    req(0, 0, 1);
    chk("ertn_pulse", bus.ecl_csr_ertn_e, 1);
    chk("ertn_ale0", bus.ecl_csr_ale_e, 0);
    step();
    req(0, 0, 0);
    chk("ertn_ecode", bus.excp_ecode, 6'h0D);
    step();
    chk("ertn_redir", bus.excp_ifu_redirect, 1);
    chk("ertn_pc", bus.excp_ifu_redirect_pc, 32'h1C000204);
    step();
    bus.lsu_excp_busy = 1'b1;
    req(1, 0, 0);
    chk("busy_pulse", bus.ecl_csr_ale_e, 1);
    step();
    req(0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      chk("busy_flush", bus.excp_pipe_flush, 1);
      chk("busy_noredir", bus.excp_ifu_redirect, 0);
      if (k == 2) begin
        req(0, 1, 0);
        chk("drain_ignore", bus.ecl_csr_illinst_e, 0);
        req(0, 0, 0);
      end
      step();
    end
    bus.lsu_excp_busy = 1'b0;
    #1;
    chk("busy_T6", bus.excp_ifu_redirect, 0);
    step();
    chk("busy_T7", bus.excp_ifu_redirect, 1);
    chk("busy_notmo", bus.excp_drain_timeout, 0);
    chk("busy_ecode", bus.excp_ecode, 6'h09);
    step();
    bus.lsu_excp_busy = 1'b1;
    req(1, 0, 0);
    step();
    req(0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      chk("stk_noredir", bus.excp_ifu_redirect, 0);
      chk("stk_notmo", bus.excp_drain_timeout, 0);
      step();
    end
    chk("stk_T15_redir", bus.excp_ifu_redirect, 0);
    step();
    chk("stk_T16_redir", bus.excp_ifu_redirect, 1);
    chk("stk_T16_tmo", bus.excp_drain_timeout, 1);
    chk("stk_pc", bus.excp_ifu_redirect_pc, 32'h1C000100);
    step();
    chk("stk_T17_redir", bus.excp_ifu_redirect, 0);
    chk("stk_T17_tmo", bus.excp_drain_timeout, 1);
    chk("stk_T17_flush", bus.excp_pipe_flush, 0);
    req(0, 1, 0);
    step();
    req(0, 0, 0);
    step();
    chk("rd_flush", bus.excp_pipe_flush, 1);
    reset = 1'b1;
    #1;
    chk("rd_redir_in", bus.excp_ifu_redirect, 0);
    step();
    reset = 1'b0;
    bus.lsu_excp_busy = 1'b0;
    #1;
    chk("rd_flush0", bus.excp_pipe_flush, 0);
    chk("rd_redir0", bus.excp_ifu_redirect, 0);
    chk("rd_ecode0", bus.excp_ecode, 0);
    chk("rd_tmo0", bus.excp_drain_timeout, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rd_noredir", bus.excp_ifu_redirect, 0);
      chk("rd_noflush", bus.excp_pipe_flush, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
